// File: rtl/mac_dot_sequencer_if.sv
// Operand-pair stream and dot-product result handshake for mac_dot_sequencer.
// The master side feeds operands and consumes results; the sequencer is the slave.
interface mac_dot_sequencer_if #(
  parameter int DW = 22,
  parameter int AW = 48
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_a;
  logic [DW-1:0] s_b;
  logic          result_valid;
  logic          result_ready;
  logic [AW-1:0] result_data;

  modport master (
    output s_valid, s_a, s_b, result_ready,
    input  s_ready, result_valid, result_data
  );

  modport slave (
    input  s_valid, s_a, s_b, result_ready,
    output s_ready, result_valid, result_data
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Issue-side controller for a pipelined MAC: streams signed operand pairs through
// MAC_LAT interleaved partial accumulators and reduces them into one dot product.
module mac_dot_sequencer #(
  parameter int VEC_LEN = 16,
  parameter int MAC_LAT = 3,
  parameter int DW      = 22,
  parameter int AW      = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  mac_dot_sequencer_if.slave    io,
  output logic                  mac_valid,
  output logic [DW-1:0]         mac_a,
  output logic [DW-1:0]         mac_b,
  output logic [AW-1:0]         mac_sum,
  input  logic                  mac_o_valid,
  input  logic [AW-1:0]         mac_sum_out,
  output logic                  busy
);

  localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(MAC_LAT - 1);
  localparam logic [CW-1:0] ELEM_LAST = CW'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    OUT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] elem_cnt_q, elem_cnt_d;
  logic [LW-1:0] lane_ptr_q, lane_ptr_d;
  logic [AW-1:0] lane_acc_q [MAC_LAT];
  logic [AW-1:0] lane_acc_d [MAC_LAT];
  logic          tag_v_q [MAC_LAT];
  logic          tag_v_d [MAC_LAT];
  logic [LW-1:0] tag_l_q [MAC_LAT];
  logic [LW-1:0] tag_l_d [MAC_LAT];
  logic          result_valid_q, result_valid_d;
  logic [AW-1:0] result_data_q, result_data_d;

  logic          accept;
  logic          ret_valid;
  logic [LW-1:0] ret_tag;
  logic          capture;
  logic          fwd;
  logic          tags_busy;
  logic [AW-1:0] lane_sum;

  assign io.s_ready = !rst && (state_q == ACCUM);
  assign accept     = io.s_valid && io.s_ready;

  // The tail of the tag pipeline lines up with the MAC's o_valid/sum_out.
  assign ret_valid = tag_v_q[MAC_LAT-1];
  assign ret_tag   = tag_l_q[MAC_LAT-1];
  assign capture   = mac_o_valid && ret_valid;
  assign fwd       = capture && (ret_tag == lane_ptr_q);

  // A lane reused exactly MAC_LAT cycles later sees its previous result returning
  // this cycle, so the fresh sum_out bypasses the not-yet-updated lane register.
  assign mac_valid = accept;
  assign mac_a     = accept ? io.s_a : '0;
  assign mac_b     = accept ? io.s_b : '0;
  assign mac_sum   = !accept ? '0 : (fwd ? mac_sum_out : lane_acc_q[lane_ptr_q]);

  assign io.result_valid = result_valid_q;
  assign io.result_data  = result_data_q;
  assign busy            = (state_q != ACCUM) || (elem_cnt_q != '0);

  always_comb begin
    tags_busy = 1'b0;
    lane_sum  = '0;
    for (int unsigned i = 0; i < MAC_LAT; i++) begin
      tags_busy = tags_busy | tag_v_q[i];
      lane_sum  = lane_sum + lane_acc_q[i];
    end
  end

  always_comb begin
    tag_v_d    = tag_v_q;
    tag_l_d    = tag_l_q;
    tag_v_d[0] = accept;
    tag_l_d[0] = lane_ptr_q;
    for (int unsigned i = 1; i < MAC_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_l_d[i] = tag_l_q[i-1];
    end
  end

  always_comb begin
    state_d        = state_q;
    elem_cnt_d     = elem_cnt_q;
    lane_ptr_d     = lane_ptr_q;
    lane_acc_d     = lane_acc_q;
    result_valid_d = result_valid_q;
    result_data_d  = result_data_q;

    if (capture) begin
      lane_acc_d[ret_tag] = mac_sum_out;
    end

    if (accept) begin
      lane_ptr_d = (lane_ptr_q == LANE_LAST) ? '0 : lane_ptr_q + LW'(1);
    end

    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (elem_cnt_q == ELEM_LAST) begin
            elem_cnt_d = '0;
            state_d    = DRAIN;
          end else begin
            elem_cnt_d = elem_cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        // An empty tag pipeline also means no capture is due this cycle.
        if (!tags_busy) begin
          result_data_d  = lane_sum;
          result_valid_d = 1'b1;
          state_d        = OUT;
        end
      end
      OUT: begin
        if (io.result_ready) begin
          for (int unsigned i = 0; i < MAC_LAT; i++) begin
            lane_acc_d[i] = '0;
          end
          lane_ptr_d     = '0;
          result_valid_d = 1'b0;
          state_d        = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ACCUM;
      elem_cnt_q     <= '0;
      lane_ptr_q     <= '0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      for (int unsigned i = 0; i < MAC_LAT; i++) begin
        lane_acc_q[i] <= '0;
        tag_v_q[i]    <= 1'b0;
        tag_l_q[i]    <= '0;
      end
    end else begin
      state_q        <= state_d;
      elem_cnt_q     <= elem_cnt_d;
      lane_ptr_q     <= lane_ptr_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      lane_acc_q     <= lane_acc_d;
      tag_v_q        <= tag_v_d;
      tag_l_q        <= tag_l_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboard bench for mac_dot_sequencer: two instances (VEC_LEN=4 and VEC_LEN=1),
// each driving a behavioural 3-deep MAC, checked against plain dot-product arithmetic.
`timescale 1ns/1ps
module tb_mac_dot_sequencer;
  localparam int DW  = 22;
  localparam int AW  = 48;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_acc = 0;
  int rr_mode = 0;  // 0: ready high, 1: ready low, 2: random
  always @(posedge clk) cyc <= cyc + 1;

  mac_dot_sequencer_if #(.DW(DW), .AW(AW)) io0 ();
  mac_dot_sequencer_if #(.DW(DW), .AW(AW)) io1 ();

  logic          mv  [2];
  logic [DW-1:0] ma  [2];
  logic [DW-1:0] mb  [2];
  logic [AW-1:0] ms  [2];
  logic          mov [2];
  logic [AW-1:0] mso [2];
  logic          bz  [2];

  mac_dot_sequencer #(.VEC_LEN(4), .MAC_LAT(LAT), .DW(DW), .AW(AW)) u_dut (
    .clk(clk), .rst(rst), .io(io0),
    .mac_valid(mv[0]), .mac_a(ma[0]), .mac_b(mb[0]), .mac_sum(ms[0]),
    .mac_o_valid(mov[0]), .mac_sum_out(mso[0]), .busy(bz[0])
  );

  mac_dot_sequencer #(.VEC_LEN(1), .MAC_LAT(LAT), .DW(DW), .AW(AW)) u_dut1 (
    .clk(clk), .rst(rst), .io(io1),
    .mac_valid(mv[1]), .mac_a(ma[1]), .mac_b(mb[1]), .mac_sum(ms[1]),
    .mac_o_valid(mov[1]), .mac_sum_out(mso[1]), .busy(bz[1])
  );

  // Behavioural MAC: sum_out = a*b + sum_in, visible LAT edges after sampling.
  logic [AW-1:0] mp  [2][LAT];
  logic          mvp [2][LAT];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int j = 0; j < LAT; j++) begin
          mvp[k][j] <= 1'b0;
          mp[k][j]  <= '0;
        end
      end else begin
        mvp[k][0] <= mv[k];
        mp[k][0]  <= AW'(longint'($signed(ma[k])) * longint'($signed(mb[k]))) + ms[k];
        for (int j = 1; j < LAT; j++) begin
          mvp[k][j] <= mvp[k][j-1];
          mp[k][j]  <= mp[k][j-1];
        end
      end
    end
  end
  assign mov[0] = mvp[0][LAT-1];
  assign mso[0] = mp[0][LAT-1];
  assign mov[1] = mvp[1][LAT-1];
  assign mso[1] = mp[1][LAT-1];

  always @(posedge clk) begin
    #1;
    io0.result_ready = (rr_mode == 0) ? 1'b1 :
                       (rr_mode == 1) ? 1'b0 : 1'($urandom_range(1, 0));
  end

  logic [AW-1:0] exp0 [$];
  logic [AW-1:0] exp1 [$];

  task automatic check_bit(input string name, input logic got, input logic req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end
  endtask

  task automatic check_val(input string name, input logic [AW-1:0] got, input logic [AW-1:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=0x%0h required=0x%0h", name, got, req);
    end
  endtask

  function automatic logic [AW-1:0] ref_dot(input logic [DW-1:0] a [4],
                                            input logic [DW-1:0] b [4], input int n);
    longint acc = 0;
    for (int i = 0; i < n; i++) acc += longint'($signed(a[i])) * longint'($signed(b[i]));
    return acc[AW-1:0];
  endfunction

  always @(negedge clk) begin : mon0
    logic [AW-1:0] e;
    if (!rst && io0.result_valid && io0.result_ready) begin
      n_tests++;
      if (exp0.size() == 0) begin
        n_fail++;
        $display("FAIL result_sb0_extra got=%0d required=none", $signed(io0.result_data));
      end else begin
        e = exp0.pop_front();
        if (io0.result_data !== e) begin
          n_fail++;
          $display("FAIL result_sb0 got=%0d required=%0d", $signed(io0.result_data), $signed(e));
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [AW-1:0] e;
    if (!rst && io1.result_valid && io1.result_ready) begin
      n_tests++;
      if (exp1.size() == 0) begin
        n_fail++;
        $display("FAIL result_sb1_extra got=%0d required=none", $signed(io1.result_data));
      end else begin
        e = exp1.pop_front();
        if (io1.result_data !== e) begin
          n_fail++;
          $display("FAIL result_sb1 got=%0d required=%0d", $signed(io1.result_data), $signed(e));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send0(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n = 0;
    io0.s_valid = 1'b1;
    io0.s_a = a;
    io0.s_b = b;
    @(negedge clk);
    while (!io0.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_bit("s_ready_wait0", io0.s_ready, 1'b1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    io0.s_valid = 1'b0;
    io0.s_a = '0;
    io0.s_b = '0;
  endtask

  task automatic send1(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n = 0;
    io1.s_valid = 1'b1;
    io1.s_a = a;
    io1.s_b = b;
    @(negedge clk);
    while (!io1.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_bit("s_ready_wait1", io1.s_ready, 1'b1);
    @(posedge clk);
    #1;
    io1.s_valid = 1'b0;
    io1.s_a = '0;
    io1.s_b = '0;
  endtask

  task automatic run_vec0(input logic [DW-1:0] a [4], input logic [DW-1:0] b [4],
                          input int gmin, input int gmax);
    exp0.push_back(ref_dot(a, b, 4));
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin
        int g;
        g = int'($urandom_range(gmax, gmin));
        repeat (g) begin
          @(negedge clk);
          check_bit("gap_s_ready", io0.s_ready, 1'b1);
          check_bit("gap_busy", bz[0], 1'b1);
          @(posedge clk);
          #1;
        end
      end
      send0(a[i], b[i]);
    end
  endtask

  task automatic wait_rv0(output int at);
    int n = 0;
    @(negedge clk);
    while (!io0.result_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_bit("rv0_timeout", io0.result_valid, 1'b1);
    at = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] va [4];
    logic [DW-1:0] vb [4];
    logic [AW-1:0] e;
    int t_rv;
    io0.s_valid = 1'b0; io0.s_a = '0; io0.s_b = '0;
    io1.s_valid = 1'b0; io1.s_a = '0; io1.s_b = '0; io1.result_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("rst_s_ready", io0.s_ready, 1'b0);
    check_bit("rst_result_valid", io0.result_valid, 1'b0);
    check_val("rst_result_data", io0.result_data, '0);
    check_bit("rst_busy", bz[0], 1'b0);
    check_bit("rst_mac_valid", mv[0], 1'b0);
    check_bit("rst1_result_valid", io1.result_valid, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_bit("idle_s_ready", io0.s_ready, 1'b1);
    check_bit("idle_busy", bz[0], 1'b0);
    @(posedge clk); #1;

    // back-to-back, latency and one-cycle result
    va = '{DW'(1), DW'(2), DW'(3), DW'(4)};
    vb = '{DW'(5), DW'(6), DW'(7), DW'(8)};
    run_vec0(va, vb, 0, 0);
    wait_rv0(t_rv);
    check_val("t1_latency", AW'(t_rv - last_acc), AW'(4));
    check_val("t1_data", io0.result_data, AW'(70));
    @(negedge clk);
    check_bit("t1_one_cycle", io0.result_valid, 1'b0);
    @(posedge clk); #1;

    // signed operands with 2-cycle gaps
    va = '{DW'(-3), DW'(7), DW'(-1), DW'(2)};
    vb = '{DW'(4), DW'(-2), DW'(-5), DW'(100)};
    run_vec0(va, vb, 2, 2);
    wait_rv0(t_rv);
    @(posedge clk); #1;

    // most negative operands, lane 0 forwarded on element 3
    va = '{DW'(-(1 << 21)), DW'(-(1 << 21)), DW'(-(1 << 21)), DW'(-(1 << 21))};
    vb = va;
    run_vec0(va, vb, 0, 0);
    wait_rv0(t_rv);
    check_val("t3_data", io0.result_data, AW'(64'h1000_0000_0000));
    @(posedge clk); #1;

    // result backpressure
    rr_mode = 1;
    for (int i = 0; i < 4; i++) begin
      va[i] = DW'($urandom);
      vb[i] = DW'($urandom);
    end
    e = ref_dot(va, vb, 4);
    run_vec0(va, vb, 0, 1);
    wait_rv0(t_rv);
    io0.s_valid = 1'b1;
    io0.s_a = DW'(123);
    io0.s_b = DW'(456);
    repeat (10) begin
      check_val("bp_data_hold", io0.result_data, e);
      check_bit("bp_valid_hold", io0.result_valid, 1'b1);
      check_bit("bp_s_ready", io0.s_ready, 1'b0);
      check_bit("bp_mac_valid", mv[0], 1'b0);
      @(negedge clk);
    end
    io0.s_valid = 1'b0;
    io0.s_a = '0;
    io0.s_b = '0;
    rr_mode = 0;
    @(posedge clk); #1;
    va = '{DW'(1), DW'(1), DW'(1), DW'(1)};
    vb = va;
    run_vec0(va, vb, 0, 0);
    wait_rv0(t_rv);
    check_val("t4_cleared", io0.result_data, AW'(4));
    @(posedge clk); #1;

    // reset after two of four accepts
    send0(DW'(1000), DW'(-77));
    send0(DW'(-5000), DW'(31));
    rst = 1'b1;
    @(negedge clk);
    check_bit("mid_rst_s_ready", io0.s_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_bit("mid_rst_busy", bz[0], 1'b0);
    check_bit("mid_rst_result_valid", io0.result_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    va = '{DW'(2), DW'(2), DW'(2), DW'(2)};
    vb = '{DW'(3), DW'(3), DW'(3), DW'(3)};
    run_vec0(va, vb, 0, 0);
    wait_rv0(t_rv);
    check_val("t5_fresh", io0.result_data, AW'(24));
    @(posedge clk); #1;

    // VEC_LEN=1 instance
    va[0] = DW'(-5);
    vb[0] = DW'(9);
    exp1.push_back(ref_dot(va, vb, 1));
    send1(va[0], vb[0]);
    begin
      int n = 0;
      @(negedge clk);
      while (!io1.result_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check_val("t6_data", io1.result_data, AW'(-45));
      @(posedge clk); #1;
    end
    repeat (8) begin
      va[0] = DW'($urandom);
      vb[0] = DW'($urandom);
      exp1.push_back(ref_dot(va, vb, 1));
      send1(va[0], vb[0]);
      repeat ($urandom_range(2, 0)) begin
        @(posedge clk); #1;
      end
    end

    // random vectors with random gaps and random result_ready
    rr_mode = 2;
    repeat (25) begin
      for (int i = 0; i < 4; i++) begin
        va[i] = DW'($urandom);
        vb[i] = DW'($urandom);
      end
      run_vec0(va, vb, 0, 2);
    end
    rr_mode = 0;
    begin
      int n = 0;
      while ((exp0.size() != 0 || exp1.size() != 0) && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check_val("sb0_drained", AW'(exp0.size()), '0);
    check_val("sb1_drained", AW'(exp1.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
